// File: rtl/vga_draw_arbiter.sv
// vga_draw_arbiter
// Shares the single VGA adapter pixel-write port among NUM_REQ drawing
// requesters. A round-robin winner is chosen in IDLE, its solid-colour
// rectangle is latched, and DRAW streams one pixel per clock in raster order.
//
// Optional feature macro: DRAW_ARB_CLIP_EN
//   defined   -> pixels whose 9-bit x/y sum falls outside SCREEN_W x SCREEN_H
//                are emitted with plot_out = 0 (the cycle is still consumed)
//   undefined -> coordinates wrap modulo 256 and every drawn pixel is plotted
//
// All outputs are registered. Each output register is loaded with the value
// for the pixel that will be on the port in the following cycle, so the grant
// cycle already carries pixel (x0, y0).
module vga_draw_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_x,
  input  logic [8*NUM_REQ-1:0]   req_y,
  input  logic [8*NUM_REQ-1:0]   req_w,
  input  logic [8*NUM_REQ-1:0]   req_h,
  input  logic [9*NUM_REQ-1:0]   req_colour,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic                   busy,
  output logic [7:0]             x_out,
  output logic [7:0]             y_out,
  output logic [8:0]             colour_out,
  output logic                   plot_out
);

  localparam int LGW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Refuse to elaborate with a requester count or screen size the 8-bit
  // coordinate datapath and packed request buses cannot represent.
  generate
    if (NUM_REQ < 2 || NUM_REQ > 8 || SCREEN_W < 1 || SCREEN_W > 256 ||
        SCREEN_H < 1 || SCREEN_H > 256) begin : g_bad_cfg
      $error("vga_draw_arbiter: unsupported parameter set");
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } state_t;

  state_t state, next_state;

  // Latched rectangle and raster position of the pixel currently on the port
  logic [LGW-1:0] last_granted;
  logic [LGW-1:0] cur_idx;
  logic [7:0]     rect_x, rect_y, rect_w, rect_h;
  logic [8:0]     rect_col;
  logic [7:0]     cx, cy;

  // Round-robin winner
  logic           any_req;
  logic [LGW-1:0] win_idx;
  logic [7:0]     win_x, win_y, win_w, win_h;
  logic [8:0]     win_col;

  // Current-pixel status
  logic cur_zero;
  logic cur_last;

  // Next-cycle datapath values
  logic           grant;
  logic           emit;
  logic [LGW-1:0] n_idx, n_last;
  logic [7:0]     n_rect_x, n_rect_y, n_rect_w, n_rect_h;
  logic [8:0]     n_rect_col;
  logic [7:0]     n_cx, n_cy;

  // Next-cycle pixel and output values
  logic [7:0]         pix_x, pix_y;
  logic               on_screen;
  logic               n_zero;
  logic               n_is_last;
  logic [NUM_REQ-1:0] n_gnt, n_done;
  logic               n_busy;
  logic [7:0]         n_x, n_y;
  logic [8:0]         n_col;
  logic               n_plot;

  assign cur_zero = (rect_w == 8'd0) || (rect_h == 8'd0);
  assign cur_last = cur_zero ||
                    ((cx == rect_w - 8'd1) && (cy == rect_h - 8'd1));

  // Pick the first requester after last_granted (wrapping), then mux its rectangle
  always_comb begin
    any_req = 1'b0;
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any_req && req[i] && (i > int'(last_granted))) begin
        any_req = 1'b1;
        win_idx = LGW'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any_req && req[i]) begin
        any_req = 1'b1;
        win_idx = LGW'(i);
      end
    end
    win_x   = '0;
    win_y   = '0;
    win_w   = '0;
    win_h   = '0;
    win_col = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (LGW'(i) == win_idx) begin
        win_x   = req_x[8*i +: 8];
        win_y   = req_y[8*i +: 8];
        win_w   = req_w[8*i +: 8];
        win_h   = req_h[8*i +: 8];
        win_col = req_colour[9*i +: 9];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic plus the raster counters and rectangle latch that follow it
  always_comb begin
    next_state = state;
    grant      = 1'b0;
    emit       = 1'b0;
    n_idx      = cur_idx;
    n_last     = last_granted;
    n_rect_x   = rect_x;
    n_rect_y   = rect_y;
    n_rect_w   = rect_w;
    n_rect_h   = rect_h;
    n_rect_col = rect_col;
    n_cx       = cx;
    n_cy       = cy;
    case (state)
      IDLE: begin
        if (any_req) begin
          next_state = DRAW;
          grant      = 1'b1;
          emit       = 1'b1;
          n_idx      = win_idx;
          n_last     = win_idx;
          n_rect_x   = win_x;
          n_rect_y   = win_y;
          n_rect_w   = win_w;
          n_rect_h   = win_h;
          n_rect_col = win_col;
          n_cx       = 8'd0;
          n_cy       = 8'd0;
        end
      end
      DRAW: begin
        if (cur_last) begin
          next_state = IDLE;
        end else begin
          emit = 1'b1;
          if (cx == rect_w - 8'd1) begin
            n_cx = 8'd0;
            n_cy = cy + 8'd1;
          end else begin
            n_cx = cx + 8'd1;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

`ifdef DRAW_ARB_CLIP_EN
  localparam logic [8:0] SCREEN_W9 = 9'(SCREEN_W);
  localparam logic [8:0] SCREEN_H9 = 9'(SCREEN_H);
  logic [8:0] sum_x, sum_y;

  // Full 9-bit pixel sums so off-screen pixels can be suppressed, not wrapped
  always_comb begin
    sum_x     = {1'b0, n_rect_x} + {1'b0, n_cx};
    sum_y     = {1'b0, n_rect_y} + {1'b0, n_cy};
    pix_x     = sum_x[7:0];
    pix_y     = sum_y[7:0];
    on_screen = (sum_x < SCREEN_W9) && (sum_y < SCREEN_H9);
  end
`else
  // Coordinates wrap modulo 256 and every drawn pixel reaches the adapter
  always_comb begin
    pix_x     = n_rect_x + n_cx;
    pix_y     = n_rect_y + n_cy;
    on_screen = 1'b1;
  end
`endif

  // Output values for the next cycle: grant/done pulses, busy and the pixel itself
  always_comb begin
    n_zero    = (n_rect_w == 8'd0) || (n_rect_h == 8'd0);
    n_is_last = n_zero ||
                ((n_cx == n_rect_w - 8'd1) && (n_cy == n_rect_h - 8'd1));
    n_gnt  = '0;
    n_done = '0;
    n_busy = 1'b0;
    n_plot = 1'b0;
    n_x    = x_out;
    n_y    = y_out;
    n_col  = colour_out;
    if (grant) begin
      n_gnt = NUM_REQ'(1) << n_idx;
    end
    if (emit) begin
      n_busy = 1'b1;
      n_x    = pix_x;
      n_y    = pix_y;
      n_col  = n_rect_col;
      n_plot = !n_zero && on_screen;
      if (n_is_last) begin
        n_done = NUM_REQ'(1) << n_idx;
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_granted <= LGW'(NUM_REQ - 1);
      cur_idx      <= '0;
      rect_x       <= '0;
      rect_y       <= '0;
      rect_w       <= '0;
      rect_h       <= '0;
      rect_col     <= '0;
      cx           <= '0;
      cy           <= '0;
      gnt          <= '0;
      done         <= '0;
      busy         <= 1'b0;
      x_out        <= '0;
      y_out        <= '0;
      colour_out   <= '0;
      plot_out     <= 1'b0;
    end else begin
      last_granted <= n_last;
      cur_idx      <= n_idx;
      rect_x       <= n_rect_x;
      rect_y       <= n_rect_y;
      rect_w       <= n_rect_w;
      rect_h       <= n_rect_h;
      rect_col     <= n_rect_col;
      cx           <= n_cx;
      cy           <= n_cy;
      gnt          <= n_gnt;
      done         <= n_done;
      busy         <= n_busy;
      x_out        <= n_x;
      y_out        <= n_y;
      colour_out   <= n_col;
      plot_out     <= n_plot;
    end
  end

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Testbench for vga_draw_arbiter: directed scenarios with literal expectations
// plus a randomized phase, all cross-checked every cycle against a
// rectangle-level reference model (pixel index -> (index mod w, index div w)).
module tb_vga_draw_arbiter;

  localparam int NR = 4;

  logic          clk;
  logic          resetn;
  logic [NR-1:0] req;
  logic [8*NR-1:0] req_x, req_y, req_w, req_h;
  logic [9*NR-1:0] req_colour;
  logic [NR-1:0] gnt, done;
  logic          busy;
  logic [7:0]    x_out, y_out;
  logic [8:0]    colour_out;
  logic          plot_out;

  int n_tests = 0;
  int n_fail  = 0;

  vga_draw_arbiter #(.NUM_REQ(NR), .SCREEN_W(160), .SCREEN_H(120)) dut (
    .clk(clk), .resetn(resetn), .req(req),
    .req_x(req_x), .req_y(req_y), .req_w(req_w), .req_h(req_h),
    .req_colour(req_colour),
    .gnt(gnt), .done(done), .busy(busy),
    .x_out(x_out), .y_out(y_out), .colour_out(colour_out), .plot_out(plot_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int i, input int x, input int y, input int w,
                               input int h, input int col);
    req_x[8*i +: 8]      = 8'(x);
    req_y[8*i +: 8]      = 8'(y);
    req_w[8*i +: 8]      = 8'(w);
    req_h[8*i +: 8]      = 8'(h);
    req_colour[9*i +: 9] = 9'(col);
    req[i]               = 1'b1;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    resetn = 1'b0;
    req    = '0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  function automatic int onehotIndex(input logic [NR-1:0] v);
    int r = -1;
    for (int i = 0; i < NR; i++) if (v[i]) r = i;
    return r;
  endfunction

  // ---------------- reference model ----------------
  bit  m_valid = 0;
  bit  m_idle;
  int  m_last, m_idx, m_x0, m_y0, m_w, m_h, m_col, m_p, m_total;
  logic [NR-1:0] e_gnt, e_done;
  logic          e_busy, e_plot;
  logic [7:0]    e_x, e_y;
  logic [8:0]    e_col;

  task automatic modelPixel();
    int px, py;
    e_busy = 1'b1;
    e_done = (m_p == m_total - 1) ? NR'(1) << m_idx : '0;
    e_col  = 9'(m_col);
    if (m_w == 0 || m_h == 0) begin
      e_x = 8'(m_x0);
      e_y = 8'(m_y0);
      e_plot = 1'b0;
    end else begin
      px = m_x0 + (m_p % m_w);
      py = m_y0 + (m_p / m_w);
      e_x = 8'(px % 256);
      e_y = 8'(py % 256);
`ifdef DRAW_ARB_CLIP_EN
      e_plot = (px < 160) && (py < 120);
`else
      e_plot = 1'b1;
`endif
    end
  endtask

  task automatic modelStep();
    int win;
    if (!resetn) begin
      m_valid = 1;
      m_idle  = 1;
      m_last  = NR - 1;
      e_gnt = '0; e_done = '0; e_busy = 0; e_plot = 0;
      e_x = '0; e_y = '0; e_col = '0;
    end else if (m_valid) begin
      e_gnt = '0; e_done = '0; e_busy = 0; e_plot = 0;
      if (m_idle) begin
        win = -1;
        for (int k = 1; k <= NR; k++)
          if (win < 0 && req[(m_last + k) % NR]) win = (m_last + k) % NR;
        if (win >= 0) begin
          m_idx   = win;
          m_last  = win;
          m_x0    = int'(req_x[8*win +: 8]);
          m_y0    = int'(req_y[8*win +: 8]);
          m_w     = int'(req_w[8*win +: 8]);
          m_h     = int'(req_h[8*win +: 8]);
          m_col   = int'(req_colour[9*win +: 9]);
          m_total = (m_w == 0 || m_h == 0) ? 1 : m_w * m_h;
          m_p     = 0;
          m_idle  = 0;
          e_gnt   = NR'(1) << win;
          modelPixel();
        end
      end else begin
        m_p++;
        if (m_p >= m_total) m_idle = 1;
        else modelPixel();
      end
    end
  endtask

  // Model advance on each edge, then compare the registered outputs 1 time unit later
  initial begin
    forever begin
      @(posedge clk);
      modelStep();
      #1;
      if (m_valid) begin
        checkOutput("model_gnt", 32'(gnt), 32'(e_gnt));
        checkOutput("model_done", 32'(done), 32'(e_done));
        checkOutput("model_busy", 32'(busy), 32'(e_busy));
        checkOutput("model_plot", 32'(plot_out), 32'(e_plot));
        checkOutput("model_x", 32'(x_out), 32'(e_x));
        checkOutput("model_y", 32'(y_out), 32'(e_y));
        checkOutput("model_colour", 32'(colour_out), 32'(e_col));
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  int exp_xs[6] = '{10, 11, 12, 10, 11, 12};
  int exp_ys[6] = '{20, 20, 20, 21, 21, 21};
  int g_idx[8];
  int g_cyc[8];
  int ng;
  int plots;

  initial begin
    resetn = 1'b0;
    req = '0; req_x = '0; req_y = '0; req_w = '0; req_h = '0; req_colour = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_plot", 32'(plot_out), 32'd0);
    checkOutput("reset_gnt", 32'(gnt), 32'd0);
    checkOutput("reset_x", 32'(x_out), 32'd0);
    resetn = 1'b1;

    // single request, 3x2 at (10,20)
    @(negedge clk);
    applyStimulus(0, 10, 20, 3, 2, 9'h1C0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checkOutput("single_gnt", 32'(gnt), 32'b0001);
        req[0] = 1'b0;
      end
      checkOutput("single_x", 32'(x_out), 32'(exp_xs[k]));
      checkOutput("single_y", 32'(y_out), 32'(exp_ys[k]));
      checkOutput("single_colour", 32'(colour_out), 32'h1C0);
      checkOutput("single_plot", 32'(plot_out), 32'd1);
      checkOutput("single_done", 32'(done), (k == 5) ? 32'b0001 : 32'd0);
    end
    @(negedge clk);
    checkOutput("single_busy_fall", 32'(busy), 32'd0);

    // zero-size rectangle
    applyStimulus(2, 5, 5, 0, 5, 9'h0F0);
    @(negedge clk);
    checkOutput("zero_gnt", 32'(gnt), 32'b0100);
    checkOutput("zero_done", 32'(done), 32'b0100);
    checkOutput("zero_plot", 32'(plot_out), 32'd0);
    req[2] = 1'b0;
    @(negedge clk);
    checkOutput("zero_busy_after", 32'(busy), 32'd0);
    checkOutput("zero_plot_after", 32'(plot_out), 32'd0);

    // edge-of-screen rectangle: clipping or wrap
    applyStimulus(1, 158, 119, 4, 2, 9'h03F);
    plots = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checkOutput("edge_gnt", 32'(gnt), 32'b0010);
        req[1] = 1'b0;
      end
      checkOutput("edge_x", 32'(x_out), 32'(158 + k % 4));
      checkOutput("edge_y", 32'(y_out), 32'(119 + k / 4));
      checkOutput("edge_done", 32'(done), (k == 7) ? 32'b0010 : 32'd0);
      if (plot_out) plots++;
    end
`ifdef DRAW_ARB_CLIP_EN
    checkOutput("edge_plot_count", 32'(plots), 32'd2);
`else
    checkOutput("edge_plot_count", 32'(plots), 32'd8);
`endif
    @(negedge clk);
    checkOutput("edge_busy_after", 32'(busy), 32'd0);

    // contention from reset: 1x1 rectangles, all requests held
    pulseReset();
    for (int i = 0; i < NR; i++) applyStimulus(i, 4 * i, 4 * i, 1, 1, 9'h100 + i);
    ng = 0;
    for (int c = 0; c < 20 && ng < 5; c++) begin
      @(negedge clk);
      if (gnt != '0) begin
        g_idx[ng] = onehotIndex(gnt);
        g_cyc[ng] = c;
        ng++;
      end
    end
    checkOutput("contention_count", 32'(ng), 32'd5);
    for (int k = 0; k < ng; k++) begin
      checkOutput("contention_order", 32'(g_idx[k]), 32'(k % 4));
      if (k > 0) checkOutput("contention_gap", 32'(g_cyc[k] - g_cyc[k-1]), 32'd2);
    end

    // reset in the middle of a 10x10 rectangle
    pulseReset();
    applyStimulus(2, 0, 0, 10, 10, 9'h0AA);
    @(negedge clk);
    checkOutput("midreset_gnt", 32'(gnt), 32'b0100);
    req = '0;
    repeat (37) @(negedge clk);
    checkOutput("midreset_px37_x", 32'(x_out), 32'd7);
    checkOutput("midreset_px37_y", 32'(y_out), 32'd3);
    resetn = 1'b0;
    @(negedge clk);
    checkOutput("midreset_plot", 32'(plot_out), 32'd0);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_done", 32'(done), 32'd0);
    resetn = 1'b1;
    for (int i = 0; i < NR; i++) applyStimulus(i, 1, 1, 1, 1, 9'h011);
    @(negedge clk);
    checkOutput("midreset_first_gnt", 32'(gnt), 32'b0001);
    req = '0;
    repeat (3) @(negedge clk);

    // reissue: requester 1 re-requests right after its grant while 3 waits
    pulseReset();
    applyStimulus(1, 20, 20, 2, 1, 9'h055);
    applyStimulus(3, 30, 30, 2, 1, 9'h066);
    ng = 0;
    for (int c = 0; c < 30 && ng < 3; c++) begin
      @(negedge clk);
      if (gnt != '0) begin
        g_idx[ng] = onehotIndex(gnt);
        ng++;
        if (g_idx[ng-1] == 1 && ng == 1) applyStimulus(1, 40, 40, 2, 1, 9'h077);
        else req[g_idx[ng-1]] = 1'b0;
      end
    end
    checkOutput("reissue_count", 32'(ng), 32'd3);
    checkOutput("reissue_first", 32'(g_idx[0]), 32'd1);
    checkOutput("reissue_second", 32'(g_idx[1]), 32'd3);
    checkOutput("reissue_third", 32'(g_idx[2]), 32'd1);
    req = '0;
    repeat (4) @(negedge clk);

    // randomized requesters, checked by the model process
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      resetn = ($urandom_range(0, 499) != 0);
      for (int i = 0; i < NR; i++) begin
        if (gnt[i]) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
          else applyStimulus(i, ($urandom_range(0, 3) == 0) ? $urandom_range(150, 255)
                                                            : $urandom_range(0, 159),
                             ($urandom_range(0, 3) == 0) ? $urandom_range(110, 255)
                                                         : $urandom_range(0, 119),
                             $urandom_range(0, 5), $urandom_range(0, 5),
                             $urandom_range(0, 511));
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          applyStimulus(i, ($urandom_range(0, 3) == 0) ? $urandom_range(150, 255)
                                                      : $urandom_range(0, 159),
                        ($urandom_range(0, 3) == 0) ? $urandom_range(110, 255)
                                                    : $urandom_range(0, 119),
                        $urandom_range(0, 5), $urandom_range(0, 5),
                        $urandom_range(0, 511));
        end
      end
    end
    resetn = 1'b1;
    req = '0;
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
